// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks FCS and length, drops the FCS and
// streams the payload with sop/eop/error flags. Define GMII_RX_STATS_EN for frame counters.
module gmii_rx_framer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 32
) (
  input  logic             rx_clk,
  input  logic             rst,
  input  logic [7:0]       rxd,
  input  logic             rx_dv,
  input  logic             rx_er,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_sop,
  output logic             m_eop,
  output logic             m_crc_err,
  output logic             m_len_err,
  output logic             m_phy_err,
  output logic [CNT_W-1:0] stat_ok,
  output logic [CNT_W-1:0] stat_bad
);

  // Output stream: m_valid marks exactly one byte per cycle; there is no ready, so the
  // consumer must take every beat. sop/eop/err are meaningful only while m_valid=1.

  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_PRE  = 2'd1;
  localparam logic [1:0]  ST_DATA = 2'd2;
  localparam logic [1:0]  ST_DROP = 2'd3;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [13:0] MIN_L       = 14'(MIN_LEN);
  localparam logic [13:0] MAX_L       = 14'(MAX_LEN);
  localparam logic [13:0] CNT_MAX     = 14'h3FFF;
  localparam logic [13:0] DLY_DEPTH   = 14'd5;

  logic [1:0]       state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [13:0]      cnt_q, cnt_d;
  logic [4:0][7:0]  dly_q, dly_d;
  logic             phy_q, phy_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             crc_err_q, crc_err_d;
  logic             len_err_q, len_err_d;
  logic             phy_err_q, phy_err_d;
  logic             evt_ok, evt_bad;
  logic             end_crc, end_len, end_phy;

  // Data bits enter LSB first against an MSB-first register, so a good frame leaves
  // the bit-reversed form of the usual 0xDEBB20E3 residue.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  assign end_crc = (crc_q != CRC_RESIDUE);
  assign end_len = (cnt_q < MIN_L) || (cnt_q > MAX_L);
  assign end_phy = phy_q | rx_er;

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    dly_d     = dly_q;
    phy_d     = phy_q;
    data_d    = 8'h00;
    valid_d   = 1'b0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    crc_err_d = 1'b0;
    len_err_d = 1'b0;
    phy_err_d = 1'b0;
    evt_ok    = 1'b0;
    evt_bad   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_dv) begin
          if (!rx_er && rxd == 8'h55) state_d = ST_PRE;
          else                        state_d = ST_DROP;
        end
      end
      ST_PRE: begin
        if (!rx_dv) begin
          state_d = ST_IDLE;
        end else if (rx_er) begin
          state_d = ST_DROP;
          evt_bad = 1'b1;
        end else if (rxd == 8'hD5) begin
          state_d = ST_DATA;
          crc_d   = 32'hFFFF_FFFF;
          cnt_d   = 14'd0;
          phy_d   = 1'b0;
        end else if (rxd != 8'h55) begin
          state_d = ST_DROP;
          evt_bad = 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_dv) begin
          crc_d = crc_byte(crc_q, rxd);
          dly_d = {dly_q[3:0], rxd};
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 14'd1;
          if (rx_er) phy_d = 1'b1;
          // The line is full once five bytes are held; the oldest is then payload.
          if (cnt_q >= DLY_DEPTH) begin
            valid_d = 1'b1;
            data_d  = dly_q[4];
            sop_d   = (cnt_q == DLY_DEPTH);
          end
        end else begin
          state_d = ST_IDLE;
          if (cnt_q >= DLY_DEPTH) begin
            valid_d   = 1'b1;
            data_d    = dly_q[4];
            sop_d     = (cnt_q == DLY_DEPTH);
            eop_d     = 1'b1;
            crc_err_d = end_crc;
            len_err_d = end_len;
            phy_err_d = end_phy;
            evt_ok    = !(end_crc || end_len || end_phy);
            evt_bad   = end_crc || end_len || end_phy;
          end else begin
            evt_bad = 1'b1;
          end
        end
      end
      default: begin
        if (!rx_dv) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      crc_q     <= 32'h0;
      cnt_q     <= 14'd0;
      dly_q     <= '0;
      phy_q     <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      crc_err_q <= 1'b0;
      len_err_q <= 1'b0;
      phy_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      dly_q     <= dly_d;
      phy_q     <= phy_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      crc_err_q <= crc_err_d;
      len_err_q <= len_err_d;
      phy_err_q <= phy_err_d;
    end
  end

  assign m_data    = data_q;
  assign m_valid   = valid_q;
  assign m_sop     = sop_q;
  assign m_eop     = eop_q;
  assign m_crc_err = crc_err_q;
  assign m_len_err = len_err_q;
  assign m_phy_err = phy_err_q;

`ifdef GMII_RX_STATS_EN
  logic [CNT_W-1:0] stat_ok_q, stat_bad_q;

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      stat_ok_q  <= '0;
      stat_bad_q <= '0;
    end else begin
      if (evt_ok && stat_ok_q != {CNT_W{1'b1}})   stat_ok_q  <= stat_ok_q + CNT_W'(1);
      if (evt_bad && stat_bad_q != {CNT_W{1'b1}}) stat_bad_q <= stat_bad_q + CNT_W'(1);
    end
  end

  assign stat_ok  = stat_ok_q;
  assign stat_bad = stat_bad_q;
`else
  logic stats_unused;
  assign stats_unused = evt_ok ^ evt_bad;
  assign stat_ok      = '0;
  assign stat_bad     = '0;
`endif

endmodule
